dbg_reg_access_ctrl: RTL and testbench

//  Sequencer for debug abstract "access register" commands. Sits between DebugModule and the

---
 rtl/dbg_pkg.sv | 28 ++
 rtl/dbg_acc_watchdog.sv | 36 +++
 rtl/dbg_reg_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dbg_reg_access_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared debug-module definitions for the abstract access-register path.
//   cmderr_e     : cmderr codes returned to the DM (the DM keeps them sticky)
//   AARSIZE_32   : the only supported aarsize (32-bit access)
//   REGNO_*      : default regno map (GPR window base, top of CSR window)
//   dra_state_e  : sequencer states
package dbg_pkg;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4,
    CMDERR_BUS        = 3'd5,
    CMDERR_OTHER      = 3'd7
  } cmderr_e;

  localparam logic [2:0]  AARSIZE_32      = 3'd2;
  localparam logic [15:0] REGNO_GPR_BASE  = 16'h1000;
  localparam logic [15:0] REGNO_CSR_LIMIT = 16'h0FFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } dra_state_e;

endpackage

// File: rtl/dbg_acc_watchdog.sv
// Bus-access timeout counter.
//   iClk/iRst : clock, async active-high reset
//   iClr      : force count to zero (used whenever no access is outstanding)
//   iEn       : count this cycle (access outstanding and not acknowledged)
//   oExpire   : this is the last permitted cycle; count reached TIMEOUT_CYCLES-1
module dbg_acc_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  input  logic iEn,
  output logic oExpire
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign oExpire = iEn && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (iClr)
      cnt_d = '0;
    else if (iEn && !oExpire)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dbg_reg_access_ctrl.sv
// Abstract "access register" sequencer between the DebugModule and the
// register-file / CSR debug access buses.
//   iCmd*/oCmdReady : command from DM (valid/ready), regno, size, write, wdata
//   oRsp*/iRspReady : response to DM, held until accepted; cmderr in oRspErr
//   oBusy           : command in flight (after accept until response handshake)
//   oRf*/iRf*       : GPR access bus (x0..x31)
//   oCsr*/iCsr*     : CSR access bus (12-bit address)
// One command at a time: decode on accept, one bus access with timeout,
// then a single response.
module dbg_reg_access_ctrl
  import dbg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] GPR_BASE       = REGNO_GPR_BASE,
  parameter logic [15:0] CSR_LIMIT      = REGNO_CSR_LIMIT
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iHalted,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdWrite,
  input  logic [15:0] iCmdRegno,
  input  logic [2:0]  iCmdSize,
  input  logic [31:0] iCmdWData,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspData,
  output logic [2:0]  oRspErr,
  output logic        oBusy,
  output logic        oRfEn,
  output logic        oRfWrite,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfWData,
  input  logic [31:0] iRfRData,
  input  logic        iRfAck,
  output logic        oCsrEn,
  output logic        oCsrWrite,
  output logic [11:0] oCsrAddr,
  output logic [31:0] oCsrWData,
  input  logic [31:0] iCsrRData,
  input  logic        iCsrAck
);

  dra_state_e  state_q, state_d;
  logic        tgt_csr_q, tgt_csr_d;
  logic        write_q, write_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  cmderr_e     rsp_err_q, rsp_err_d;

  logic [15:0] gpr_off;
  logic        is_gpr, is_csr, issuing, ack, wd_expire;

  // GPR window is 32 entries starting at GPR_BASE; checked before the CSR window.
  assign gpr_off = iCmdRegno - GPR_BASE;
  assign is_gpr  = (iCmdRegno >= GPR_BASE) && (gpr_off[15:5] == '0);
  assign is_csr  = (iCmdRegno <= CSR_LIMIT);

  // Enables are pure state decode so an async reset drops them at once.
  assign issuing = (state_q == ISSUE);
  assign ack     = tgt_csr_q ? iCsrAck : iRfAck;

  dbg_acc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .iClk    (iClk),
    .iRst    (iRst),
    .iClr    (!issuing),
    .iEn     (issuing && !ack),  // ack on the final cycle still wins
    .oExpire (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    tgt_csr_d  = tgt_csr_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (iCmdValid) begin
          write_d    = iCmdWrite;
          wdata_d    = iCmdWData;
          rsp_data_d = '0;
          rsp_err_d  = CMDERR_NONE;
          state_d    = ISSUE;
          if (!iHalted) begin
            rsp_err_d = CMDERR_HALTRESUME;
            state_d   = RESP;
          end else if (iCmdSize != AARSIZE_32) begin
            rsp_err_d = CMDERR_NOTSUP;
            state_d   = RESP;
          end else if (is_gpr) begin
            tgt_csr_d = 1'b0;
            addr_d    = {7'd0, gpr_off[4:0]};
          end else if (is_csr) begin
            tgt_csr_d = 1'b1;
            addr_d    = iCmdRegno[11:0];
          end else begin
            rsp_err_d = CMDERR_NOTSUP;
            state_d   = RESP;
          end
        end
      end
      ISSUE: begin
        if (ack) begin
          rsp_data_d = write_q ? '0 : (tgt_csr_q ? iCsrRData : iRfRData);
          rsp_err_d  = CMDERR_NONE;
          state_d    = RESP;
        end else if (wd_expire) begin
          rsp_data_d = '0;
          rsp_err_d  = CMDERR_EXCEPTION;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (iRspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      tgt_csr_q  <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= CMDERR_NONE;
    end else begin
      state_q    <= state_d;
      tgt_csr_q  <= tgt_csr_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign oCmdReady = (state_q == IDLE);
  assign oRspValid = (state_q == RESP);
  assign oBusy     = (state_q != IDLE);
  assign oRspData  = rsp_data_q;
  assign oRspErr   = rsp_err_q;

  assign oRfEn     = issuing && !tgt_csr_q;
  assign oRfWrite  = oRfEn && write_q;
  assign oRfAddr   = addr_q[4:0];
  assign oRfWData  = wdata_q;

  assign oCsrEn    = issuing && tgt_csr_q;
  assign oCsrWrite = oCsrEn && write_q;
  assign oCsrAddr  = addr_q;
  assign oCsrWData = wdata_q;

endmodule

// File: tb/tb_dbg_reg_access_ctrl.sv
// Self-checking bench for dbg_reg_access_ctrl: directed scenarios plus
// randomized commands checked against a regno-map / timeout reference model.
module tb_dbg_reg_access_ctrl;

  logic        iClk = 1'b0;
  logic        iRst, iHalted, iCmdValid, iCmdWrite, iRspReady;
  logic [15:0] iCmdRegno;
  logic [2:0]  iCmdSize;
  logic [31:0] iCmdWData, iRfRData, iCsrRData;
  logic        iRfAck, iCsrAck;
  logic        oCmdReady, oRspValid, oBusy;
  logic [31:0] oRspData;
  logic [2:0]  oRspErr;
  logic        oRfEn, oRfWrite, oCsrEn, oCsrWrite;
  logic [4:0]  oRfAddr;
  logic [11:0] oCsrAddr;
  logic [31:0] oRfWData, oCsrWData;

  dbg_reg_access_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iHalted(iHalted),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
    .iCmdRegno(iCmdRegno), .iCmdSize(iCmdSize), .iCmdWData(iCmdWData),
    .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData),
    .oRspErr(oRspErr), .oBusy(oBusy),
    .oRfEn(oRfEn), .oRfWrite(oRfWrite), .oRfAddr(oRfAddr), .oRfWData(oRfWData),
    .iRfRData(iRfRData), .iRfAck(iRfAck),
    .oCsrEn(oCsrEn), .oCsrWrite(oCsrWrite), .oCsrAddr(oCsrAddr),
    .oCsrWData(oCsrWData), .iCsrRData(iCsrRData), .iCsrAck(iCsrAck)
  );

  always #5 iClk = ~iClk;

  int n_chk = 0;
  int n_fail = 0;

  // Bus responder: ack once the enable has been high for ack_dly earlier cycles.
  int ack_dly;
  int en_cnt;
  always @(posedge iClk or posedge iRst)
    if (iRst) en_cnt <= 0;
    else      en_cnt <= (oRfEn || oCsrEn) ? en_cnt + 1 : 0;
  assign iRfAck  = oRfEn  && (en_cnt == ack_dly);
  assign iCsrAck = oCsrEn && (en_cnt == ack_dly);

  // Bus monitor, sampled mid-cycle.
  logic        mon_clr;
  int          rf_cyc, csr_cyc;
  logic        both_en, mon_wr;
  logic [4:0]  mon_rf_addr;
  logic [11:0] mon_csr_addr;
  logic [31:0] mon_wd;
  always @(negedge iClk) begin
    if (mon_clr) begin
      rf_cyc <= 0; csr_cyc <= 0; both_en <= 1'b0; mon_wr <= 1'b0;
      mon_rf_addr <= '0; mon_csr_addr <= '0; mon_wd <= '0;
    end else begin
      if (oRfEn) begin
        rf_cyc <= rf_cyc + 1; mon_rf_addr <= oRfAddr; mon_wr <= oRfWrite; mon_wd <= oRfWData;
      end
      if (oCsrEn) begin
        csr_cyc <= csr_cyc + 1; mon_csr_addr <= oCsrAddr; mon_wr <= oCsrWrite; mon_wd <= oCsrWData;
      end
      if (oRfEn && oCsrEn) both_en <= 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  err;
    logic [31:0] data;
    int          lat;
    logic        to, rdy_before, rdy_after, busy1, both, wr;
    int          rf_cyc, csr_cyc;
    logic [4:0]  rf_addr;
    logic [11:0] csr_addr;
    logic [31:0] wd;
  } obs_t;

  typedef struct {
    logic [2:0]  err;
    logic [31:0] data;
    int          lat, en, tgt;  // tgt: 0 none, 1 RF, 2 CSR
    logic [11:0] addr;
  } exp_t;

  localparam logic [31:0] CSR_XOR = 32'h5A5A_5A5A;

  // Reference: regno map, error priority, timeout of 16 enable cycles.
  function automatic exp_t model(logic h, logic w, logic [15:0] rn, logic [2:0] sz,
                                 logic [31:0] rd, int dly);
    exp_t e;
    e.err = 3'd0; e.tgt = 0; e.addr = '0; e.data = '0; e.en = 0; e.lat = 1;
    if (!h)                                 e.err = 3'd4;
    else if (sz != 3'd2)                    e.err = 3'd2;
    else if (rn >= 16'h1000 && rn < 16'h1020) begin e.tgt = 1; e.addr = 12'(rn - 16'h1000); end
    else if (rn <= 16'h0FFF)                begin e.tgt = 2; e.addr = rn[11:0]; end
    else                                    e.err = 3'd2;
    if (e.tgt != 0) begin
      if (dly >= 16) begin e.err = 3'd3; e.en = 16; end
      else e.en = dly + 1;
      e.lat = e.en + 1;
      if (e.err == 3'd0 && !w) e.data = (e.tgt == 1) ? rd : (rd ^ CSR_XOR);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge iClk); #1;
  endtask

  // Issue one command, wait (bounded) for the response, then accept it.
  task automatic run_cmd(input logic h, input logic w, input logic [15:0] rn,
                         input logic [2:0] sz, input logic [31:0] wd, input int dly,
                         input logic [31:0] rd, output obs_t o);
    iHalted = h; iCmdWrite = w; iCmdRegno = rn; iCmdSize = sz; iCmdWData = wd;
    ack_dly = dly; iRfRData = rd; iCsrRData = rd ^ CSR_XOR;
    o.rdy_before = oCmdReady;
    iCmdValid = 1'b1; mon_clr = 1'b1;
    step();
    iCmdValid = 1'b0; mon_clr = 1'b0;
    o.busy1 = oBusy;
    o.lat = 1;
    while (!oRspValid && o.lat < 60) begin step(); o.lat++; end
    o.to = !oRspValid;
    if (o.to) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout: no oRspValid within %0d cycles (regno %h)", o.lat, rn);
    end
    o.err = oRspErr; o.data = oRspData;
    iRspReady = 1'b1;
    step();
    iRspReady = 1'b0;
    o.rdy_after = oCmdReady;
    o.rf_cyc = rf_cyc; o.csr_cyc = csr_cyc; o.both = both_en;
    o.rf_addr = mon_rf_addr; o.csr_addr = mon_csr_addr; o.wr = mon_wr; o.wd = mon_wd;
  endtask

  task automatic test_reset();
    iRst = 1'b1; mon_clr = 1'b1;
    iHalted = 0; iCmdValid = 0; iCmdWrite = 0; iCmdRegno = '0; iCmdSize = '0;
    iCmdWData = '0; iRspReady = 0; iRfRData = '0; iCsrRData = '0; ack_dly = 0;
    repeat (2) step();
    n_chk++;
    if ({oCmdReady, oRspValid, oBusy, oRfEn, oCsrEn, oRfWrite, oCsrWrite} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 1000000",
               {oCmdReady, oRspValid, oBusy, oRfEn, oCsrEn, oRfWrite, oCsrWrite});
    end
    n_chk++;
    if (oRspData !== 0 || oRspErr !== 0 || oRfAddr !== 0 || oCsrAddr !== 0 ||
        oRfWData !== 0 || oCsrWData !== 0) begin
      n_fail++;
      $display("FAIL reset_data: data %h err %0d rfaddr %h csraddr %h exp all 0",
               oRspData, oRspErr, oRfAddr, oCsrAddr);
    end
    iRst = 1'b0;
    step();
    mon_clr = 1'b0;
    n_chk++;
    if (oCmdReady !== 1'b1 || oBusy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_ready: ready %b busy %b exp 1 0", oCmdReady, oBusy);
    end
  endtask

  task automatic test_rf_read();
    obs_t o;
    run_cmd(1'b1, 1'b0, 16'h1005, 3'd2, 32'h0, 0, 32'hDEADBEEF, o);
    n_chk++;
    if (o.lat !== 2) begin n_fail++; $display("FAIL t1_latency: got %0d exp 2", o.lat); end
    n_chk++;
    if (o.data !== 32'hDEADBEEF || o.err !== 3'd0) begin
      n_fail++; $display("FAIL t1_rsp: data %h err %0d exp deadbeef 0", o.data, o.err);
    end
    n_chk++;
    if (o.rf_cyc !== 1 || o.csr_cyc !== 0 || o.rf_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL t1_bus: rf_cyc %0d csr_cyc %0d addr %0d exp 1 0 5", o.rf_cyc, o.csr_cyc, o.rf_addr);
    end
    n_chk++;
    if (o.rdy_after !== 1'b1) begin n_fail++; $display("FAIL t1_ready_after: got %b exp 1", o.rdy_after); end
  endtask

  task automatic test_csr_write();
    obs_t o;
    run_cmd(1'b1, 1'b1, 16'h0341, 3'd2, 32'h80000004, 3, 32'h11112222, o);
    n_chk++;
    if (o.csr_addr !== 12'h341 || o.wr !== 1'b1 || o.wd !== 32'h80000004) begin
      n_fail++;
      $display("FAIL t2_bus: addr %h wr %b wd %h exp 341 1 80000004", o.csr_addr, o.wr, o.wd);
    end
    n_chk++;
    if (o.rf_cyc !== 0 || o.csr_cyc !== 4 || o.lat !== 5) begin
      n_fail++;
      $display("FAIL t2_timing: rf_cyc %0d csr_cyc %0d lat %0d exp 0 4 5", o.rf_cyc, o.csr_cyc, o.lat);
    end
    n_chk++;
    if (o.err !== 3'd0 || o.data !== 32'h0) begin
      n_fail++; $display("FAIL t2_rsp: err %0d data %h exp 0 0", o.err, o.data);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic        hs [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  szs[3] = '{3'd2, 3'd3, 3'd2};
    logic [15:0] rns[3] = '{16'h1005, 16'h1005, 16'h2000};
    logic [2:0]  ers[3] = '{3'd4, 3'd2, 3'd2};
    for (int i = 0; i < 3; i++) begin
      run_cmd(hs[i], 1'b0, rns[i], szs[i], 32'h0, 0, 32'hAAAA5555, o);
      n_chk++;
      if (o.err !== ers[i] || o.lat !== 1 || o.data !== 0 || (o.rf_cyc + o.csr_cyc) !== 0) begin
        n_fail++;
        $display("FAIL t3_err%0d: err %0d lat %0d data %h en_cyc %0d exp %0d 1 0 0",
                 i, o.err, o.lat, o.data, o.rf_cyc + o.csr_cyc, ers[i]);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_cmd(1'b1, 1'b0, 16'h1001, 3'd2, 32'h0, 99, 32'h0BADF00D, o);
    n_chk++;
    if (o.rf_cyc !== 16 || o.err !== 3'd3 || o.data !== 0 || o.lat !== 17) begin
      n_fail++;
      $display("FAIL t4_timeout: en_cyc %0d err %0d data %h lat %0d exp 16 3 0 17",
               o.rf_cyc, o.err, o.data, o.lat);
    end
    run_cmd(1'b1, 1'b0, 16'h1001, 3'd2, 32'h0, 15, 32'h0BADF00D, o);
    n_chk++;
    if (o.rf_cyc !== 16 || o.err !== 3'd0 || o.data !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL t4_last_ack: en_cyc %0d err %0d data %h exp 16 0 0badf00d", o.rf_cyc, o.err, o.data);
    end
  endtask

  task automatic test_backpressure();
    iHalted = 1; iCmdWrite = 0; iCmdRegno = 16'h1007; iCmdSize = 3'd2; ack_dly = 0;
    iRfRData = 32'h12345678; iCsrRData = 32'h0;
    iCmdValid = 1'b1; mon_clr = 1'b1;
    step();
    iCmdValid = 1'b0; mon_clr = 1'b0;
    step();
    n_chk++;
    if (oRspValid !== 1'b1 || oRspData !== 32'h12345678) begin
      n_fail++; $display("FAIL t5_first_rsp: valid %b data %h exp 1 12345678", oRspValid, oRspData);
    end
    iCmdValid = 1'b1; iCmdWrite = 1'b1; iCmdRegno = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if ({oRspValid, oCmdReady, oRfEn, oCsrEn} !== 4'b1000 || oRspData !== 32'h12345678 ||
          oRspErr !== 3'd0) begin
        n_fail++;
        $display("FAIL t5_hold%0d: vld/rdy/rf/csr %b data %h err %0d exp 1000 12345678 0",
                 k, {oRspValid, oCmdReady, oRfEn, oCsrEn}, oRspData, oRspErr);
      end
    end
    iCmdValid = 1'b0; iRspReady = 1'b1;
    step();
    iRspReady = 1'b0;
    n_chk++;
    if (oCmdReady !== 1'b1 || oRspValid !== 1'b0 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_release: ready %b valid %b busy %b exp 1 0 0", oCmdReady, oRspValid, oBusy);
    end
    n_chk++;
    if (rf_cyc !== 1 || csr_cyc !== 0) begin
      n_fail++; $display("FAIL t5_no_queue: rf_cyc %0d csr_cyc %0d exp 1 0", rf_cyc, csr_cyc);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic saw_rsp;
    iHalted = 1; iCmdWrite = 0; iCmdRegno = 16'h1003; iCmdSize = 3'd2; ack_dly = 99;
    iCmdValid = 1'b1; mon_clr = 1'b1;
    step();
    iCmdValid = 1'b0; mon_clr = 1'b0;
    step(); step();
    n_chk++;
    if (oRfEn !== 1'b1) begin n_fail++; $display("FAIL t6_in_issue: rf_en %b exp 1", oRfEn); end
    iRst = 1'b1;
    #1;
    n_chk++;
    if ({oRfEn, oCsrEn, oRspValid, oCmdReady, oBusy} !== 5'b00010) begin
      n_fail++;
      $display("FAIL t6_abort: rf/csr/vld/rdy/busy %b exp 00010", {oRfEn, oCsrEn, oRspValid, oCmdReady, oBusy});
    end
    saw_rsp = 1'b0;
    repeat (3) begin step(); if (oRspValid || oRfEn) saw_rsp = 1'b1; end
    iRst = 1'b0;
    repeat (2) begin step(); if (oRspValid || oRfEn) saw_rsp = 1'b1; end
    n_chk++;
    if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL t6_no_rsp: saw rsp/en %b exp 0", saw_rsp); end
    run_cmd(1'b1, 1'b0, 16'h1003, 3'd2, 32'h0, 1, 32'hCAFEF00D, o);
    n_chk++;
    if (o.err !== 3'd0 || o.data !== 32'hCAFEF00D || o.lat !== 3 || o.rf_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL t6_after: err %0d data %h lat %0d addr %0d exp 0 cafef00d 3 3",
               o.err, o.data, o.lat, o.rf_addr);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] edges[6] = '{16'h0000, 16'h0FFF, 16'h1000, 16'h101F, 16'h1020, 16'hFFFF};
    for (int i = 0; i < 40; i++) begin
      logic h, w;
      logic [15:0] rn;
      logic [2:0]  sz;
      logic [31:0] wd, rd;
      int dly;
      h  = ($urandom_range(0, 7) != 0);
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
      wd = $urandom; rd = $urandom;
      dly = $urandom_range(0, 18);
      case ($urandom_range(0, 3))
        0:       rn = 16'h1000 + 16'($urandom_range(0, 31));
        1:       rn = 16'($urandom_range(0, 4095));
        2:       rn = edges[$urandom_range(0, 5)];
        default: rn = 16'($urandom);
      endcase
      e = model(h, w, rn, sz, rd, dly);
      run_cmd(h, w, rn, sz, wd, dly, rd, o);
      n_chk++;
      if (o.err !== e.err || o.data !== e.data || o.lat !== e.lat) begin
        n_fail++;
        $display("FAIL rnd%0d_rsp: regno %h err %0d data %h lat %0d exp %0d %h %0d",
                 i, rn, o.err, o.data, o.lat, e.err, e.data, e.lat);
      end
      n_chk++;
      if (o.rf_cyc !== ((e.tgt == 1) ? e.en : 0) || o.csr_cyc !== ((e.tgt == 2) ? e.en : 0) ||
          o.both !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_en: regno %h rf_cyc %0d csr_cyc %0d both %b exp tgt %0d cyc %0d",
                 i, rn, o.rf_cyc, o.csr_cyc, o.both, e.tgt, e.en);
      end
      if (e.tgt != 0) begin
        n_chk++;
        if (((e.tgt == 1) ? {7'd0, o.rf_addr} : o.csr_addr) !== e.addr || o.wr !== w || o.wd !== wd) begin
          n_fail++;
          $display("FAIL rnd%0d_addr: rf %h csr %h wr %b wd %h exp addr %h wr %b wd %h",
                   i, o.rf_addr, o.csr_addr, o.wr, o.wd, e.addr, w, wd);
        end
      end
      n_chk++;
      if (o.rdy_before !== 1'b1 || o.busy1 !== 1'b1 || o.rdy_after !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd%0d_hs: rdy_before %b busy %b rdy_after %b exp 1 1 1",
                 i, o.rdy_before, o.busy1, o.rdy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rf_read();
    test_csr_write();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
